// File: rtl/pan_controller.sv
// Camera pan controller: debounced pan buttons drive a saturating pan position and
// emit at most one renderer shift pulse per frame, aligned to the start of vertical blanking.
`timescale 1ns/1ps

module pan_debounce #(
  parameter int CYCLES = 1_000_000,
  parameter int CNT_W  = 20
) (
  input  logic clk_100MHz,
  input  logic reset_n,
  input  logic btn,
  output logic deb
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);

  logic             btn_m;
  logic             btn_s;
  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      btn_m <= 1'b0;
      btn_s <= 1'b0;
      cnt   <= '0;
      deb   <= 1'b0;
    end else begin
      btn_m <= btn;
      btn_s <= btn_m;
      // Any sample agreeing with the accepted level restarts the stability count.
      if (btn_s == deb) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        deb <= btn_s;
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end
endmodule

module pan_controller #(
  parameter int DEBOUNCE_CYCLES    = 1_000_000,
  parameter int STEP_PERIOD_FRAMES = 2,
  parameter int POS_MAX            = 200
) (
  input  logic       clk_100MHz,
  input  logic       reset_n,
  input  logic       btn_r,
  input  logic       btn_l,
  input  logic [9:0] y,
  output logic       shift_r,
  output logic       shift_l,
  output logic [7:0] pan_pos,
  output logic       at_min,
  output logic       at_max
);
  localparam int CNT_W  = ($clog2(DEBOUNCE_CYCLES) > 20) ? $clog2(DEBOUNCE_CYCLES) : 20;
  localparam int FCNT_W = (STEP_PERIOD_FRAMES > 1) ? $clog2(STEP_PERIOD_FRAMES) : 1;
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(STEP_PERIOD_FRAMES - 1);
  localparam logic [7:0]        POS_TOP   = 8'(POS_MAX);
  localparam logic [9:0]        VB_LINE   = 10'd480;

  typedef enum logic {S_IDLE, S_REPEAT} state_t;
  typedef enum logic [1:0] {DIR_NONE, DIR_R, DIR_L} dir_t;

  logic              deb_r;
  logic              deb_l;
  logic              vb;
  logic              vb_d;
  logic              vb_start;
  dir_t              dir;
  dir_t              cur_dir;
  dir_t              cur_dir_nxt;
  dir_t              step_dir;
  state_t            state;
  state_t            state_nxt;
  logic [FCNT_W-1:0] fcnt;
  logic [FCNT_W-1:0] fcnt_nxt;
  logic [7:0]        pos_nxt;
  logic              shift_r_nxt;
  logic              shift_l_nxt;

  pan_debounce #(.CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb_r (
    .clk_100MHz (clk_100MHz),
    .reset_n    (reset_n),
    .btn        (btn_r),
    .deb        (deb_r)
  );

  pan_debounce #(.CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb_l (
    .clk_100MHz (clk_100MHz),
    .reset_n    (reset_n),
    .btn        (btn_l),
    .deb        (deb_l)
  );

  // y sits on line 480 for many clocks; only its first clock opens a step window.
  assign vb       = (y == VB_LINE);
  assign vb_start = vb & ~vb_d;

  // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
  always_comb begin
    dir = DIR_NONE;
    if (deb_r && !deb_l)      dir = DIR_R;
    else if (deb_l && !deb_r) dir = DIR_L;
  end

  always_comb begin
    state_nxt   = state;
    cur_dir_nxt = cur_dir;
    fcnt_nxt    = fcnt;
    step_dir    = DIR_NONE;
    if (vb_start) begin
      case (state)
        S_IDLE: begin
          if (dir != DIR_NONE) begin
            step_dir    = dir;
            cur_dir_nxt = dir;
            fcnt_nxt    = '0;
            state_nxt   = S_REPEAT;
          end
        end
        S_REPEAT: begin
          if (dir == DIR_NONE) begin
            state_nxt = S_IDLE;
          end else if (dir != cur_dir) begin
            step_dir    = dir;
            cur_dir_nxt = dir;
            fcnt_nxt    = '0;
          end else if (fcnt == FCNT_LAST) begin
            step_dir = cur_dir;
            fcnt_nxt = '0;
          end else begin
            fcnt_nxt = fcnt + FCNT_W'(1);
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // A step against a travel limit is swallowed: no pulse, position unchanged.
  always_comb begin
    pos_nxt     = pan_pos;
    shift_r_nxt = 1'b0;
    shift_l_nxt = 1'b0;
    if (step_dir == DIR_R && pan_pos < POS_TOP) begin
      pos_nxt     = pan_pos + 8'd1;
      shift_r_nxt = 1'b1;
    end else if (step_dir == DIR_L && pan_pos != 8'd0) begin
      pos_nxt     = pan_pos - 8'd1;
      shift_l_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      vb_d    <= 1'b0;
      state   <= S_IDLE;
      cur_dir <= DIR_NONE;
      fcnt    <= '0;
      pan_pos <= 8'd0;
      shift_r <= 1'b0;
      shift_l <= 1'b0;
      at_min  <= 1'b1;
      at_max  <= 1'b0;
    end else begin
      vb_d    <= vb;
      state   <= state_nxt;
      cur_dir <= cur_dir_nxt;
      fcnt    <= fcnt_nxt;
      pan_pos <= pos_nxt;
      shift_r <= shift_r_nxt;
      shift_l <= shift_l_nxt;
      at_min  <= (pos_nxt == 8'd0);
      at_max  <= (pos_nxt == POS_TOP);
    end
  end
endmodule

// File: tb/tb_pan_controller.sv
// Self-checking bench for pan_controller: directed scenarios plus random button traffic,
// all compared against a frame-level behavioural model of the pan rules.
`timescale 1ns/1ps

module tb_pan_controller;
  localparam int DEB       = 4;
  localparam int PER       = 2;
  localparam int PMAX      = 3;
  localparam int LINES     = 525;
  localparam int LINE_CLKS = 2;
  localparam int HIST      = DEB + 2;
  localparam int WAIT_MAX  = 3000;

  logic       clk_100MHz;
  logic       reset_n;
  logic       btn_r;
  logic       btn_l;
  logic [9:0] y;
  logic       shift_r;
  logic       shift_l;
  logic [7:0] pan_pos;
  logic       at_min;
  logic       at_max;

  int n_cmp  = 0;
  int n_fail = 0;
  int cnt_r  = 0;
  int cnt_l  = 0;
  int track_pos = 0;
  bit deb_r_seen = 0;

  pan_controller #(
    .DEBOUNCE_CYCLES    (DEB),
    .STEP_PERIOD_FRAMES (PER),
    .POS_MAX            (PMAX)
  ) dut (
    .clk_100MHz (clk_100MHz),
    .reset_n    (reset_n),
    .btn_r      (btn_r),
    .btn_l      (btn_l),
    .y          (y),
    .shift_r    (shift_r),
    .shift_l    (shift_l),
    .pan_pos    (pan_pos),
    .at_min     (at_min),
    .at_max     (at_max)
  );

  initial begin
    clk_100MHz = 1'b0;
    forever #5 clk_100MHz = ~clk_100MHz;
  end

  // Scan-line generator: 525 lines per frame, each line held for LINE_CLKS clocks.
  initial begin
    y = '0;
    forever begin
      for (int line = 0; line < LINES; line++) begin
        for (int c = 0; c < LINE_CLKS; c++) begin
          y = 10'(line);
          @(posedge clk_100MHz);
          #1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: raw button history, frame-start detection and the pan rules.
  bit hist_r [HIST];
  bit hist_l [HIST];
  bit m_deb_r = 0, m_deb_l = 0, m_vbd = 0, m_active = 0, m_sr = 0, m_sl = 0;
  int m_held = 0, m_frames = 0, m_pos = 0;

  initial begin
    bit flip_r, flip_l, vbs;
    int req, step;
    forever begin
      @(posedge clk_100MHz or negedge reset_n);
      if (!reset_n) begin
        for (int i = 0; i < HIST; i++) begin
          hist_r[i] = 0;
          hist_l[i] = 0;
        end
        m_deb_r = 0; m_deb_l = 0; m_vbd = 0; m_active = 0;
        m_held = 0; m_frames = 0; m_pos = 0; m_sr = 0; m_sl = 0;
      end else begin
        for (int i = 0; i < HIST - 1; i++) begin
          hist_r[i] = hist_r[i+1];
          hist_l[i] = hist_l[i+1];
        end
        hist_r[HIST-1] = btn_r;
        hist_l[HIST-1] = btn_l;
        req = (m_deb_r && !m_deb_l) ? 1 : (m_deb_l && !m_deb_r) ? 2 : 0;
        vbs = (y == 10'd480) && !m_vbd;
        m_vbd = (y == 10'd480);
        // Accepted level flips once the two-clock-old raw value has opposed it DEB times running.
        flip_r = 1;
        flip_l = 1;
        for (int i = 0; i < DEB; i++) begin
          if (hist_r[i] == m_deb_r) flip_r = 0;
          if (hist_l[i] == m_deb_l) flip_l = 0;
        end
        if (flip_r) m_deb_r = !m_deb_r;
        if (flip_l) m_deb_l = !m_deb_l;
        m_sr = 0;
        m_sl = 0;
        if (vbs) begin
          step = 0;
          if (req == 0) begin
            m_active = 0;
          end else if (!m_active || req != m_held) begin
            m_active = 1;
            m_held = req;
            m_frames = 0;
            step = req;
          end else begin
            m_frames++;
            if (m_frames == PER) begin
              m_frames = 0;
              step = req;
            end
          end
          if (step == 1 && m_pos < PMAX) begin m_pos++; m_sr = 1; end
          if (step == 2 && m_pos > 0)    begin m_pos--; m_sl = 1; end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk_100MHz);
      check("model_shift_r", shift_r, m_sr);
      check("model_shift_l", shift_l, m_sl);
      check("model_pan_pos", pan_pos, m_pos);
      check("model_at_min", at_min, m_pos == 0);
      check("model_at_max", at_max, m_pos == PMAX);
      if (shift_r) cnt_r++;
      if (shift_l) cnt_l++;
      if (dut.deb_r) deb_r_seen = 1;
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_100MHz);
      #2;
    end
  endtask

  // Returns in the first clock where y reads 480; the DUT samples it at the next edge.
  task automatic wait_vb();
    int guard = 0;
    while (y == 10'd480 && guard < WAIT_MAX) begin tick(1); guard++; end
    while (y != 10'd480 && guard < WAIT_MAX) begin tick(1); guard++; end
    if (guard >= WAIT_MAX) check("frame_wait_timeout", guard, 0);
  endtask

  task automatic wait_line(input int line);
    int guard = 0;
    while (y != 10'(line) && guard < WAIT_MAX) begin tick(1); guard++; end
    if (guard >= WAIT_MAX) check("line_wait_timeout", guard, 0);
  endtask

  // Hold one button for nframes frames, pressed just after a frame start.
  task automatic hold_run(input bit go_right, input int nframes, input string tag);
    bit exp;
    wait_vb();
    tick(1);
    if (go_right) btn_r = 1; else btn_l = 1;
    for (int f = 0; f < nframes; f++) begin
      wait_vb();
      check($sformatf("%s_pre_f%0d", tag, f), go_right ? shift_r : shift_l, 0);
      tick(1);
      exp = 0;
      if (f % PER == 0) begin
        if (go_right && track_pos < PMAX) begin track_pos++; exp = 1; end
        if (!go_right && track_pos > 0)   begin track_pos--; exp = 1; end
      end
      check($sformatf("%s_pulse_f%0d", tag, f), go_right ? shift_r : shift_l, exp);
      check($sformatf("%s_other_f%0d", tag, f), go_right ? shift_l : shift_r, 0);
      tick(1);
      check($sformatf("%s_width_f%0d", tag, f), go_right ? shift_r : shift_l, 0);
      check($sformatf("%s_pos_f%0d", tag, f), pan_pos, track_pos);
    end
    btn_r = 0;
    btn_l = 0;
    check({tag, "_at_max"}, at_max, track_pos == PMAX);
    check({tag, "_at_min"}, at_min, track_pos == 0);
  endtask

  initial begin
    int snap_r, snap_l;
    btn_r = 0;
    btn_l = 0;
    reset_n = 0;
    tick(3);
    check("reset_shift_r", shift_r, 0);
    check("reset_shift_l", shift_l, 0);
    check("reset_pan_pos", pan_pos, 0);
    check("reset_at_min", at_min, 1);
    check("reset_at_max", at_max, 0);
    reset_n = 1;
    tick(2);

    // Bounce: runs of 3 equal samples never satisfy a 4-cycle debounce.
    deb_r_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0) btn_r = !btn_r;
      tick(1);
    end
    btn_r = 0;
    tick(20);
    check("bounce_deb_r", deb_r_seen, 0);
    check("bounce_shift_r", cnt_r, 0);

    track_pos = 0;
    hold_run(1, 8, "hold_r");
    check("hold_r_count", cnt_r, 3);

    // Mid-frame reset with the position at its limit.
    wait_line(100);
    reset_n = 0;
    #1;
    check("midrst_shift_r", shift_r, 0);
    check("midrst_shift_l", shift_l, 0);
    check("midrst_pan_pos", pan_pos, 0);
    check("midrst_at_min", at_min, 1);
    check("midrst_at_max", at_max, 0);
    tick(3);
    reset_n = 1;
    track_pos = 0;
    snap_r = cnt_r;
    snap_l = cnt_l;
    repeat (3) wait_vb();
    tick(2);
    check("midrst_idle_r", cnt_r - snap_r, 0);
    check("midrst_idle_l", cnt_l - snap_l, 0);

    hold_run(1, 6, "refill");
    wait_vb();
    snap_l = cnt_l;
    hold_run(0, 8, "hold_l");
    check("hold_l_count", cnt_l - snap_l, 3);

    // Both buttons: drop to idle with no pulse, then left alone steps on the next frame.
    wait_vb();
    tick(1);
    btn_r = 1;
    wait_vb();
    tick(1);
    check("both_first_r", shift_r, 1);
    tick(1);
    btn_l = 1;
    snap_r = cnt_r;
    snap_l = cnt_l;
    repeat (2) begin
      wait_vb();
      tick(2);
    end
    check("both_none_r", cnt_r - snap_r, 0);
    check("both_none_l", cnt_l - snap_l, 0);
    check("both_pos", pan_pos, 1);
    btn_r = 0;
    wait_vb();
    tick(1);
    check("both_release_l", shift_l, 1);
    tick(1);
    check("both_release_pos", pan_pos, 0);
    btn_l = 0;

    // Reset while repeating; release just before a frame start so debounce cannot finish in time.
    wait_vb();
    tick(1);
    btn_r = 1;
    wait_vb();
    tick(1);
    check("rstrep_step", shift_r, 1);
    tick(100);
    reset_n = 0;
    #1;
    check("rstrep_pan_pos", pan_pos, 0);
    check("rstrep_at_min", at_min, 1);
    tick(5);
    wait_line(479);
    reset_n = 1;
    wait_vb();
    tick(1);
    check("rstrep_early", shift_r, 0);
    wait_vb();
    tick(1);
    check("rstrep_first", shift_r, 1);
    tick(1);
    check("rstrep_pos", pan_pos, 1);
    btn_r = 0;

    // Random button traffic, including short bounces and simultaneous presses.
    for (int k = 0; k < 60; k++) begin
      btn_r = 1'($urandom_range(0, 1));
      btn_l = 1'($urandom_range(0, 1));
      tick(int'($urandom_range(1, 300)));
    end
    btn_r = 0;
    btn_l = 0;
    tick(50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
